// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised synchronous FIFO; define SYNC_FIFO_FWFT_EN for first-word-fall-through
module sync_fifo_param #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          almost_full_q, almost_full_d;
  logic          almost_empty_q, almost_empty_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_ok, rd_ok;

  // Accept/reject decisions, pointer/occupancy update and registered flag values
  always_comb begin
    wr_ok          = wr_en & ~full_q;
    rd_ok          = rd_en & ~empty_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d         = (count_d == FULL_CNT);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_CNT);
    almost_empty_d = (count_d <= AE_CNT);
    overflow_d     = overflow_q  | (wr_en & full_q);
    underflow_d    = underflow_q | (rd_en & empty_q);
  end

  // Pointer, occupancy and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage is never cleared; reset only forgets it by zeroing the pointers
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always visible; masked to zero while nothing is stored
  always_comb begin
    rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
    rd_valid = ~empty_q;
  end
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Capture head word on an accepted pop; otherwise hold the last popped word
  always_comb begin
    rd_data_d  = rd_ok ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_ok;
  end

  // Registered read output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
